// File: rtl/nanov_mmio_periph.sv
// nanov_mmio_periph: MMIO page at 0x1000_0000 behind the nanoV data port.
// GPIO out/in, UART TX with a small FIFO, UART RX with a one-byte buffer and
// a free-running cycle counter. Define NANOV_MMIO_GPIO_OE_EN to add the
// gpio_oe port plus the GPIO_OE / GPIO_OUT_SET / GPIO_OUT_CLR registers.
module nanov_mmio_periph #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int GPIO_W        = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    input  logic              store_addr,
    input  logic              store_data,
    input  logic              data_read,
    output logic [31:0]       rdata_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
`ifdef NANOV_MMIO_GPIO_OE_EN
    output logic [GPIO_W-1:0] gpio_oe,
`endif
    output logic              uart_tx,
    input  logic              uart_rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(TX_FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE      = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
    localparam logic [19:0] PAGE = 20'h10000;

    localparam logic [9:0] OFF_GPIO_OUT  = 10'h000;
    localparam logic [9:0] OFF_GPIO_IN   = 10'h001;
    localparam logic [9:0] OFF_UART_DATA = 10'h002;
    localparam logic [9:0] OFF_UART_STAT = 10'h003;
    localparam logic [9:0] OFF_CYCLES    = 10'h004;
`ifdef NANOV_MMIO_GPIO_OE_EN
    localparam logic [9:0] OFF_GPIO_OE   = 10'h005;
    localparam logic [9:0] OFF_GPIO_SET  = 10'h006;
    localparam logic [9:0] OFF_GPIO_CLR  = 10'h007;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:2]       addr_q;
    logic [GPIO_W-1:0] gpio_s1, gpio_s2;
    logic [31:0]       cycles;
    logic [31:0]       rd_word;

    logic [7:0]        fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_empty, fifo_full, push, push_ok, pop;

    logic [1:0]        tx_st;
    logic [CNT_W-1:0]  tx_cnt;
    logic [2:0]        tx_bit;
    logic [7:0]        tx_sh;
    logic              tx_busy;

    logic              rx_s1, rx_s2, rx_prev;
    logic [1:0]        rx_st;
    logic [CNT_W-1:0]  rx_cnt;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_sh, rx_byte;
    logic              rx_valid, rx_overrun;

    logic              wr_hit, rd_hit, pop_rx, clr_ovr;
    logic [9:0]        cur_off;
    logic              unused_bits;

    assign unused_bits = ^{addr_in[1:0], wdata_in};

    // Writes and read side effects both target the latched address.
    assign cur_off = addr_q[11:2];
    assign wr_hit  = store_data && (addr_q[31:12] == PAGE);
    assign rd_hit  = data_read && (addr_q[31:12] == PAGE);
    assign pop_rx  = rd_hit && (cur_off == OFF_UART_DATA);
    assign clr_ovr = rd_hit && (cur_off == OFF_UART_STAT);

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign tx_busy    = !fifo_empty || (tx_st != S_IDLE);
    // Shifter takes the next byte from IDLE or at the end of a stop bit.
    assign pop     = !fifo_empty &&
                     ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_cnt == BIT_LAST));
    assign push    = wr_hit && (cur_off == OFF_UART_DATA);
    assign push_ok = push && (!fifo_full || pop);

    // Register read decode on the incoming address, using pre-edge state.
    always_comb begin
        rd_word = '0;
        if (addr_in[31:12] == PAGE) begin
            case (addr_in[11:2])
                OFF_GPIO_OUT:  rd_word[GPIO_W-1:0] = gpio_out;
                OFF_GPIO_IN:   rd_word[GPIO_W-1:0] = gpio_s2;
                OFF_UART_DATA: rd_word[7:0] = rx_byte;
                OFF_UART_STAT: rd_word[3:0] = {rx_overrun, tx_busy, rx_valid, fifo_full};
                OFF_CYCLES:    rd_word = cycles;
`ifdef NANOV_MMIO_GPIO_OE_EN
                OFF_GPIO_OE:   rd_word[GPIO_W-1:0] = gpio_oe;
`endif
                default:       rd_word = '0;
            endcase
        end
    end

    // Address latch; the read word is frozen until the next address strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q    <= '0;
            rdata_out <= '0;
        end else if (store_addr) begin
            addr_q    <= addr_in[31:2];
            rdata_out <= rd_word;
        end
    end

    // GPIO output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gpio_out <= '0;
`ifdef NANOV_MMIO_GPIO_OE_EN
            gpio_oe  <= '0;
`endif
        end else if (wr_hit) begin
            case (cur_off)
                OFF_GPIO_OUT: gpio_out <= wdata_in[GPIO_W-1:0];
`ifdef NANOV_MMIO_GPIO_OE_EN
                OFF_GPIO_OE:  gpio_oe  <= wdata_in[GPIO_W-1:0];
                OFF_GPIO_SET: gpio_out <= gpio_out | wdata_in[GPIO_W-1:0];
                OFF_GPIO_CLR: gpio_out <= gpio_out & ~wdata_in[GPIO_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for gpio_in plus the free-running cycle counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
            cycles  <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            cycles  <= cycles + 32'd1;
        end
    end

    // FIFO storage; a full-FIFO push only lands when the same edge pops.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= wdata_in[7:0];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FIFO_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - FIFO_ONE;
                default: ;
            endcase
        end
    end

    // TX 8N1 shifter; uart_tx is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_st   <= S_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (tx_st)
                S_IDLE: if (pop) begin
                    tx_st   <= S_START;
                    tx_sh   <= fifo_mem[rd_ptr];
                    tx_cnt  <= '0;
                    uart_tx <= 1'b0;
                end
                S_START: if (tx_cnt == BIT_LAST) begin
                    tx_st   <= S_DATA;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    uart_tx <= tx_sh[0];
                end else tx_cnt <= tx_cnt + CNT_ONE;
                S_DATA: if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (tx_bit == 3'd7) begin
                        tx_st   <= S_STOP;
                        uart_tx <= 1'b1;
                    end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        tx_sh   <= {1'b0, tx_sh[7:1]};
                        uart_tx <= tx_sh[1];
                    end
                end else tx_cnt <= tx_cnt + CNT_ONE;
                default: if (tx_cnt == BIT_LAST) begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_st   <= S_START;
                        tx_sh   <= fifo_mem[rd_ptr];
                        uart_tx <= 1'b0;
                    end else tx_st <= S_IDLE;
                end else tx_cnt <= tx_cnt + CNT_ONE;
            endcase
        end
    end

    // RX: synchronise, find a falling edge, sample mid-bit, buffer one byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            // CPU pops/clears first; a byte landing this edge overrides below.
            if (pop_rx)  rx_valid   <= 1'b0;
            if (clr_ovr) rx_overrun <= 1'b0;
            case (rx_st)
                S_IDLE: if (rx_prev && !rx_s2) begin
                    rx_st  <= S_START;
                    rx_cnt <= '0;
                end
                S_START: if (rx_cnt == BIT_MID) begin
                    rx_st  <= rx_s2 ? S_IDLE : S_DATA;
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end else rx_cnt <= rx_cnt + CNT_ONE;
                S_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_st <= S_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt + CNT_ONE;
                default: if (rx_cnt == BIT_LAST) begin
                    rx_st  <= S_IDLE;
                    rx_cnt <= '0;
                    if (rx_s2) begin
                        rx_byte  <= rx_sh;
                        rx_valid <= 1'b1;
                        if (rx_valid && !pop_rx) rx_overrun <= 1'b1;
                    end
                end else rx_cnt <= rx_cnt + CNT_ONE;
            endcase
        end
    end

endmodule
